int_request_controller: RTL and testbench

Interrupt request controller for the CPU core: edge-captures one non-maskable and `N_SRC` maskable interrupt lines, prioritises them, and drives `INTREQ` into the CAR latch control. When `INTREQ` and `IF` are both high, the microsequencer branches to the interrupt microroutine. At that same edge this block latches the winning vector address, clears the winner's pending flag, and holds off further requests until the microroutine reports completion.

---
 rtl/int_request_controller.sv | 140 ++++++++++++++
 tb/tb_int_request_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int_request_controller.sv
// Interrupt request controller: edge-captures one NMI and N_SRC maskable
// lines, prioritises them (NMI first, then highest maskable index), raises
// INTREQ toward the CAR latch control and latches the winning vector when
// the microsequencer takes the interrupt at an instruction-fetch boundary.
module int_request_controller #(
    parameter int          N_SRC    = 8,
    parameter logic [15:0] VEC_BASE = 16'hFFE0,
    parameter logic [15:0] VEC_NMI  = 16'hFFFC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic [N_SRC-1:0] ien,
    input  logic             nmi,
    input  logic             GIE,
    input  logic             IF,
    input  logic             INTDONE,
    output logic             INTREQ,
    output logic [15:0]      INTVEC,
    output logic             INTNMI,
    output logic [N_SRC:0]   pend
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_SERVICE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_q;
    logic             nmi_q;
    logic [N_SRC-1:0] irq_pend_q, irq_pend_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic [15:0]      vec_q, vec_d;
    logic             vec_nmi_q, vec_nmi_d;

    logic [N_SRC-1:0] irq_edge;
    logic             nmi_edge;
    logic [N_SRC-1:0] irq_elig;
    logic             any_elig;
    logic             win_nmi;
    logic [15:0]      win_vec;
    logic [N_SRC-1:0] win_mask;
    logic             accept;
    logic             intreq_c;

    // Rising edge relative to the previous sample; since the samples reset
    // to 0, a line already high at reset release counts as an edge.
    assign irq_edge = irq & ~irq_q;
    assign nmi_edge = nmi & ~nmi_q;

    // GIE and ien only mask; they never touch the pending flags themselves.
    assign irq_elig = irq_pend_q & ien & {N_SRC{GIE}};
    assign any_elig = nmi_pend_q | (|irq_elig);

    // Winner selection from registered pending state: NMI first, otherwise
    // the highest eligible maskable index (later loop iterations override).
    always_comb begin
        win_nmi  = nmi_pend_q;
        win_vec  = VEC_NMI;
        win_mask = '0;
        if (!nmi_pend_q) begin
            win_vec = VEC_BASE;
            for (int i = 0; i < N_SRC; i++) begin
                if (irq_elig[i]) begin
                    win_vec  = VEC_BASE + 16'(2 * i);
                    win_mask = N_SRC'(1) << i;
                end
            end
        end
    end

    // Two-state FSM: IDLE requests while anything is eligible, SERVICE
    // suppresses requests until the microroutine signals completion.
    always_comb begin
        state_d  = state_q;
        intreq_c = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                intreq_c = any_elig;
                if (IF && any_elig) begin
                    accept  = 1'b1;
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (INTDONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending and vector next-state: the winner clears on acceptance, but a
    // fresh edge in that same cycle re-sets it (set dominates clear).
    always_comb begin
        irq_pend_d = irq_pend_q | irq_edge;
        nmi_pend_d = nmi_pend_q | nmi_edge;
        vec_d      = vec_q;
        vec_nmi_d  = vec_nmi_q;
        if (accept) begin
            vec_d     = win_vec;
            vec_nmi_d = win_nmi;
            if (win_nmi) begin
                nmi_pend_d = nmi_edge;
            end else begin
                irq_pend_d = (irq_pend_q & ~win_mask) | irq_edge;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            irq_q      <= '0;
            nmi_q      <= 1'b0;
            irq_pend_q <= '0;
            nmi_pend_q <= 1'b0;
            vec_q      <= 16'h0000;
            vec_nmi_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq;
            nmi_q      <= nmi;
            irq_pend_q <= irq_pend_d;
            nmi_pend_q <= nmi_pend_d;
            vec_q      <= vec_d;
            vec_nmi_q  <= vec_nmi_d;
        end
    end

    assign INTREQ = intreq_c;
    assign INTVEC = vec_q;
    assign INTNMI = vec_nmi_q;
    assign pend   = {nmi_pend_q, irq_pend_q};

endmodule

// File: tb/tb_int_request_controller.sv
// Directed testbench for int_request_controller (N_SRC = 8).
module tb_int_request_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic [7:0]  ien;
    logic        nmi;
    logic        GIE;
    logic        IF;
    logic        INTDONE;
    logic        INTREQ;
    logic [15:0] INTVEC;
    logic        INTNMI;
    logic [8:0]  pend;

    int checks = 0;
    int errors = 0;

    int_request_controller #(
        .N_SRC   (8),
        .VEC_BASE(16'hFFE0),
        .VEC_NMI (16'hFFFC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .ien    (ien),
        .nmi    (nmi),
        .GIE    (GIE),
        .IF     (IF),
        .INTDONE(INTDONE),
        .INTREQ (INTREQ),
        .INTVEC (INTVEC),
        .INTNMI (INTNMI),
        .pend   (pend)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq = 8'hFF; ien = 8'hFF; nmi = 1'b1;
        GIE = 1'b1; IF = 1'b1; INTDONE = 1'b1;
        tick(); tick();
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL rst_intreq got %b want 0", INTREQ); end
        checks++; if (INTVEC !== 16'h0000) begin errors++; $display("FAIL rst_intvec got %h want 0000", INTVEC); end
        checks++; if (INTNMI !== 1'b0) begin errors++; $display("FAIL rst_intnmi got %b want 0", INTNMI); end
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL rst_pend got %h want 000", pend); end
        irq = 8'h00; nmi = 1'b0; IF = 1'b0; INTDONE = 1'b0; rst = 1'b1;
        tick();
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL rel_pend got %h want 000", pend); end
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL rel_intreq got %b want 0", INTREQ); end
        // A line held high across reset release is captured once active.
        rst = 1'b0; irq = 8'h01; tick();
        rst = 1'b1; tick();
        checks++; if (pend !== 9'h001) begin errors++; $display("FAIL held_pend got %h want 001", pend); end
        rst = 1'b0; irq = 8'h00; tick();
        rst = 1'b1; tick();
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL rerst_pend got %h want 000", pend); end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        GIE = 1'b1; ien = 8'hFF;
        irq = 8'h08; tick(); irq = 8'h00;
        checks++; if (pend !== 9'h008) begin errors++; $display("FAIL single_pend got %h want 008", pend); end
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", INTREQ); end
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE6) begin errors++; $display("FAIL single_vec got %h want FFE6", INTVEC); end
        checks++; if (INTNMI !== 1'b0) begin errors++; $display("FAIL single_nmi got %b want 0", INTNMI); end
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL single_clr got %h want 000", pend); end
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL single_svc_req got %b want 0", INTREQ); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL single_done_req got %b want 0", INTREQ); end
        checks++; if (INTVEC !== 16'hFFE6) begin errors++; $display("FAIL single_hold got %h want FFE6", INTVEC); end
        $display("test_single done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_priority();
        GIE = 1'b0; irq = 8'h42; nmi = 1'b1; tick(); irq = 8'h00; nmi = 1'b0;
        checks++; if (pend !== 9'h142) begin errors++; $display("FAIL prio_pend got %h want 142", pend); end
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL prio_req got %b want 1", INTREQ); end
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFFC) begin errors++; $display("FAIL prio_nmi_vec got %h want FFFC", INTVEC); end
        checks++; if (INTNMI !== 1'b1) begin errors++; $display("FAIL prio_nmi_flag got %b want 1", INTNMI); end
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL prio_svc_req got %b want 0", INTREQ); end
        checks++; if (pend !== 9'h042) begin errors++; $display("FAIL prio_pend2 got %h want 042", pend); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL prio_gie0_req got %b want 0", INTREQ); end
        GIE = 1'b1; #1;
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL prio_gie1_req got %b want 1", INTREQ); end
        IF = 1'b1; tick();
        checks++; if (INTVEC !== 16'hFFEC) begin errors++; $display("FAIL prio_vec6 got %h want FFEC", INTVEC); end
        checks++; if (INTNMI !== 1'b0) begin errors++; $display("FAIL prio_flag6 got %b want 0", INTNMI); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL prio_b2b_req got %b want 1", INTREQ); end
        tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE2) begin errors++; $display("FAIL prio_vec1 got %h want FFE2", INTVEC); end
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL prio_pend3 got %h want 000", pend); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        $display("test_priority done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_masking();
        ien = 8'hFB; irq = 8'h04; tick(); irq = 8'h00;
        IF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL mask_req[%0d] got %b want 0", i, INTREQ); end
            checks++; if (pend !== 9'h004) begin errors++; $display("FAIL mask_pend[%0d] got %h want 004", i, pend); end
            tick();
        end
        IF = 1'b0;
        ien = 8'hFF; #1;
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL mask_en_req got %b want 1", INTREQ); end
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE4) begin errors++; $display("FAIL mask_vec got %h want FFE4", INTVEC); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        $display("test_masking done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_edge_during_service();
        irq = 8'h01; tick(); irq = 8'h00;
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE0) begin errors++; $display("FAIL eds_vec0 got %h want FFE0", INTVEC); end
        irq = 8'h20; tick(); irq = 8'h00;
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL eds_req got %b want 0", INTREQ); end
        checks++; if (pend !== 9'h020) begin errors++; $display("FAIL eds_pend got %h want 020", pend); end
        tick();
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL eds_req2 got %b want 0", INTREQ); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL eds_done_req got %b want 1", INTREQ); end
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFEA) begin errors++; $display("FAIL eds_vec5 got %h want FFEA", INTVEC); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        $display("test_edge_during_service done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_simultaneous();
        irq = 8'h08; tick(); irq = 8'h00; tick();
        irq = 8'h08; nmi = 1'b1; IF = 1'b1; tick();
        irq = 8'h00; nmi = 1'b0; IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE6) begin errors++; $display("FAIL sim_vec got %h want FFE6", INTVEC); end
        checks++; if (INTNMI !== 1'b0) begin errors++; $display("FAIL sim_nmi got %b want 0", INTNMI); end
        checks++; if (pend !== 9'h108) begin errors++; $display("FAIL sim_pend got %h want 108", pend); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFFC) begin errors++; $display("FAIL sim_vec_nmi got %h want FFFC", INTVEC); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE6) begin errors++; $display("FAIL sim_vec_re got %h want FFE6", INTVEC); end
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL sim_pend_end got %h want 000", pend); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        $display("test_simultaneous done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid_service();
        irq = 8'h10; tick(); irq = 8'h00;
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE8) begin errors++; $display("FAIL rms_vec got %h want FFE8", INTVEC); end
        irq = 8'h10; tick(); irq = 8'h00;
        checks++; if (pend !== 9'h010) begin errors++; $display("FAIL rms_pend got %h want 010", pend); end
        rst = 1'b0; tick(); rst = 1'b1;
        checks++; if (pend !== 9'h000) begin errors++; $display("FAIL rms_pend_clr got %h want 000", pend); end
        checks++; if (INTVEC !== 16'h0000) begin errors++; $display("FAIL rms_vec_clr got %h want 0000", INTVEC); end
        checks++; if (INTREQ !== 1'b0) begin errors++; $display("FAIL rms_req got %b want 0", INTREQ); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        irq = 8'h02; tick(); irq = 8'h00;
        checks++; if (INTREQ !== 1'b1) begin errors++; $display("FAIL rms_idle_req got %b want 1", INTREQ); end
        IF = 1'b1; tick(); IF = 1'b0;
        checks++; if (INTVEC !== 16'hFFE2) begin errors++; $display("FAIL rms_vec1 got %h want FFE2", INTVEC); end
        INTDONE = 1'b1; tick(); INTDONE = 1'b0;
        $display("test_reset_mid_service done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst = 1'b0; irq = 8'h00; ien = 8'hFF; nmi = 1'b0;
        GIE = 1'b1; IF = 1'b0; INTDONE = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_edge_during_service();
        test_simultaneous();
        test_reset_mid_service();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
